// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Used by fetch_queue and fetch_sequencer.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_STEP = 4;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fq_entry_t;

    // Decode asks for 0..3 words; 3 means 2, and it can never take more than is queued.
    function automatic logic [1:0] clamp_take(input logic [1:0] req, input int unsigned avail);
        logic [1:0] want;
        want = (req == 2'd3) ? 2'd2 : req;
        if (avail < 32'(want)) begin
            clamp_take = 2'(avail);
        end else begin
            clamp_take = want;
        end
    endfunction

endpackage : fetch_pkg

// File: rtl/fetch_queue.sv
// DEPTH-entry circular fetch buffer: one push per cycle, 0-2 pops per cycle, flush.
// Exposes the head and head+1 entries combinationally.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  fq_entry_t        push_entry,
    input  logic [1:0]       pop_cnt,
    output logic [CNT_W-1:0] count,
    output fq_entry_t        head,
    output fq_entry_t        head_next
);

    fq_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // NOTE: every next-state signal gets its hold value first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // The caller keeps pop_cnt <= count and never pushes into a full queue.
            rd_ptr_d = rd_ptr_q + PTR_W'(pop_cnt);
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
            count_d  = count_q + CNT_W'(push) - CNT_W'(pop_cnt);
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset; count alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    assign count     = count_q;
    assign head      = mem_q[rd_ptr_q];
    assign head_next = mem_q[rd_ptr_q + PTR_W'(1)];

endmodule : fetch_queue

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: PC register, push/redirect control and the fetch queue.
// Optional stall statistics counter enabled by defining FETCH_STATS_EN.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic [1:0]         dec_take,
    output logic               slot0_valid,
    output logic [31:0]        slot0_instr,
    output logic [ADDR_W-1:0]  slot0_pc,
    output logic               slot1_valid,
    output logic [31:0]        slot1_instr,
    output logic [ADDR_W-1:0]  slot1_pc,
    output logic               q_full,
    output logic [31:0]        stall_cycles
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  count;
    logic              push;
    logic [1:0]        eff_take;
    fq_entry_t         push_entry;
    fq_entry_t         head;
    fq_entry_t         head_next;
    logic              unused_redirect_low;

    // Memory ignores the low two bits of the redirect target.
    assign unused_redirect_low = ^redirect_pc[1:0];

    assign imem_addr = pc_q;
    assign q_full    = (count == CNT_W'(DEPTH));

    always_comb begin
        push             = !redirect_valid && !q_full;
        eff_take         = clamp_take(dec_take, 32'(count));
        push_entry.pc    = 32'(pc_q);
        push_entry.instr = imem_rdata;
        pc_d             = pc_q;
        if (redirect_valid) begin
            pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
        end else if (push) begin
            pc_d = pc_q + ADDR_W'(PC_STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // A redirect flushes the queue, which also discards that cycle's push and pops.
    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (redirect_valid),
        .push       (push),
        .push_entry (push_entry),
        .pop_cnt    (eff_take),
        .count      (count),
        .head       (head),
        .head_next  (head_next)
    );

    assign slot0_valid = (count != '0);
    assign slot1_valid = (count >= CNT_W'(2));
    assign slot0_instr = head.instr;
    assign slot0_pc    = ADDR_W'(head.pc);
    assign slot1_instr = head_next.instr;
    assign slot1_pc    = ADDR_W'(head_next.pc);

`ifdef FETCH_STATS_EN
    logic [31:0] stall_q, stall_d;

    // Counts cycles lost to a full queue that decode is not draining; saturates.
    always_comb begin
        stall_d = stall_q;
        if (q_full && (eff_take == 2'd0) && !redirect_valid && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 32'h0;
`endif

endmodule : fetch_sequencer
